legv8_bus_ctrl: RTL and testbench

Parametrised memory-bus controller for the LEGv8 multi-cycle datapath. It replaces the shared tristate data/address bus with a point-to-point, muxed interface. It decodes an address into one of NUM_REGIONS memory regions, inserts per-region wait states, generates byte-lane enables for byte/half/word/dword accesses, and aligns and extends read data. It sits between the datapath's memory-access control fields (MW, size, address, B operand) and the RAM/ROM instances.

---
 rtl/legv8_bus_pkg.sv | 40 ++++
 rtl/legv8_bus_ctrl_if.sv | 32 +++
 rtl/legv8_addr_decode.sv | 42 ++++
 rtl/legv8_bus_ctrl.sv | 163 ++++++++++++++++
 tb/tb_legv8_bus_ctrl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/legv8_bus_pkg.sv
// rtl/legv8_bus_pkg.sv - shared size/state encodings and lane helpers for the LEGv8 bus controller
package legv8_bus_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_e;

  // Byte-lane enables for an 8-lane bus; narrower buses take the low lanes.
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] offset);
    logic [7:0] m;
    case (size)
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      2'b10:   m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << offset;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] addr_lo);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = addr_lo[0];
      2'b10:   bad = |addr_lo[1:0];
      default: bad = |addr_lo;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/legv8_bus_ctrl_if.sv
// rtl/legv8_bus_ctrl_if.sv - datapath-side and memory-side signals of the bus controller
interface legv8_bus_ctrl_if #(
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 32,
  parameter int NUM_REGIONS = 2
);
  logic                          req;
  logic                          we;
  logic [1:0]                    size;
  logic                          sext;
  logic [ADDR_W-1:0]             addr;
  logic [DATA_W-1:0]             wdata;
  logic                          ready;
  logic                          err;
  logic [DATA_W-1:0]             rdata;
  logic [NUM_REGIONS-1:0]        mem_sel;
  logic                          mem_we;
  logic [ADDR_W-1:0]             mem_addr;
  logic [DATA_W/8-1:0]           mem_be;
  logic [DATA_W-1:0]             mem_wdata;
  logic [NUM_REGIONS*DATA_W-1:0] mem_rdata;

  modport slave (
    input  req, we, size, sext, addr, wdata, mem_rdata,
    output ready, err, rdata, mem_sel, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req, we, size, sext, addr, wdata, mem_rdata,
    input  ready, err, rdata, mem_sel, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/legv8_addr_decode.sv
// rtl/legv8_addr_decode.sv - combinational region decoder, lowest matching index wins
module legv8_addr_decode
  import legv8_bus_pkg::*;
#(
  parameter int                            ADDR_W      = 32,
  parameter int                            NUM_REGIONS = 2,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {32'h20000000, 32'h00000000},
  parameter logic [NUM_REGIONS*8-1:0]      REGION_AW   = {8'd10, 8'd8}
) (
  input  logic [ADDR_W-1:0]      i_addr,
  output logic [NUM_REGIONS-1:0] o_hit,
  output logic                   o_miss,
  output logic [ADDR_W-1:0]      o_off_addr
);

  function automatic logic [ADDR_W-1:0] span_mask(input logic [7:0] aw);
    logic [ADDR_W-1:0] f;
    for (int b = 0; b < ADDR_W; b++) begin
      f[b] = (b < int'(aw));
    end
    return f;
  endfunction

  // Scan from the top index down so the lowest matching region is the last to overwrite.
  always_comb begin
    logic [ADDR_W-1:0] m;
    o_hit      = '0;
    o_off_addr = '0;
    m          = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      m = span_mask(REGION_AW[i*8 +: 8]);
      if (((i_addr ^ REGION_BASE[i*ADDR_W +: ADDR_W]) & ~m) == '0) begin
        o_hit      = '0;
        o_hit[i]   = 1'b1;
        o_off_addr = i_addr & m;
      end
    end
  end

  assign o_miss = ~|o_hit;

endmodule

// File: rtl/legv8_bus_ctrl.sv
// rtl/legv8_bus_ctrl.sv - LEGv8 memory-bus controller: decode, wait states, lane steering, read extension
module legv8_bus_ctrl
  import legv8_bus_pkg::*;
#(
  parameter int                            DATA_W      = 64,
  parameter int                            ADDR_W      = 32,
  parameter int                            NUM_REGIONS = 2,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {32'h20000000, 32'h00000000},
  parameter logic [NUM_REGIONS*8-1:0]      REGION_AW   = {8'd10, 8'd8},
  parameter logic [NUM_REGIONS*4-1:0]      REGION_WAIT = {4'd1, 4'd0}
) (
  input logic              clock,
  input logic              reset,
  legv8_bus_ctrl_if.slave  bus
);

  localparam int         LANES    = DATA_W / 8;
  localparam logic [2:0] OFF_MASK = 3'(LANES - 1);

  logic [NUM_REGIONS-1:0] w_hit;
  logic                   w_miss;
  logic [ADDR_W-1:0]      w_off_addr;
  logic [2:0]             w_off;
  logic                   w_err;
  logic [3:0]             w_wait;
  logic [7:0]             w_mask8;
  logic [DATA_W-1:0]      w_slice;
  logic [DATA_W-1:0]      w_shift;
  logic [DATA_W-1:0]      w_rd_ext;

  state_e                 r_state;
  logic [3:0]             r_wait;
  logic                   r_we;
  logic [1:0]             r_size;
  logic                   r_sext;
  logic [2:0]             r_off;
  logic                   r_ready;
  logic                   r_err;
  logic [DATA_W-1:0]      r_rdata;
  logic [NUM_REGIONS-1:0] r_mem_sel;
  logic                   r_mem_we;
  logic [ADDR_W-1:0]      r_mem_addr;
  logic [LANES-1:0]       r_mem_be;
  logic [DATA_W-1:0]      r_mem_wdata;

  legv8_addr_decode #(
    .ADDR_W      (ADDR_W),
    .NUM_REGIONS (NUM_REGIONS),
    .REGION_BASE (REGION_BASE),
    .REGION_AW   (REGION_AW)
  ) u_decode (
    .i_addr     (bus.addr),
    .o_hit      (w_hit),
    .o_miss     (w_miss),
    .o_off_addr (w_off_addr)
  );

  assign w_off   = bus.addr[2:0] & OFF_MASK;
  assign w_err   = w_miss | misaligned(bus.size, bus.addr[2:0]) |
                   ((DATA_W == 32) && (bus.size == SZ_D));
  assign w_mask8 = lane_mask(bus.size, w_off);

  always_comb begin
    w_wait = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (w_hit[i]) w_wait = REGION_WAIT[i*4 +: 4];
    end
  end

  always_comb begin
    w_slice = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (r_mem_sel[i]) w_slice = w_slice | bus.mem_rdata[i*DATA_W +: DATA_W];
    end
  end

  assign w_shift = w_slice >> {r_off, 3'b000};

  // Keep the low 8<<size bits, then fill above them with the sign bit or zeros.
  always_comb begin
    int               nbits;
    logic [DATA_W-1:0] keep;
    nbits = 8 << r_size;
    if (nbits > DATA_W) nbits = DATA_W;
    for (int b = 0; b < DATA_W; b++) begin
      keep[b] = (b < nbits);
    end
    if (r_sext && w_shift[nbits-1]) w_rd_ext = w_shift | ~keep;
    else                             w_rd_ext = w_shift & keep;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_wait      <= '0;
      r_we        <= 1'b0;
      r_size      <= '0;
      r_sext      <= 1'b0;
      r_off       <= '0;
      r_ready     <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_mem_sel   <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        IDLE, RESP: begin
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          r_state <= IDLE;
          if (bus.req) begin
            if (w_err) begin
              r_state <= RESP;
              r_ready <= 1'b1;
              r_err   <= 1'b1;
              r_rdata <= '0;
            end else begin
              r_state     <= ACCESS;
              r_we        <= bus.we;
              r_size      <= bus.size;
              r_sext      <= bus.sext;
              r_off       <= w_off;
              r_wait      <= w_wait;
              r_mem_sel   <= w_hit;
              r_mem_addr  <= w_off_addr & ~ADDR_W'(OFF_MASK);
              r_mem_be    <= w_mask8[LANES-1:0];
              r_mem_wdata <= bus.wdata << {w_off, 3'b000};
              r_mem_we    <= bus.we && (w_wait == 4'd0);
            end
          end
        end
        ACCESS: begin
          if (r_wait != 4'd0) begin
            r_wait   <= r_wait - 4'd1;
            r_mem_we <= r_we && (r_wait == 4'd1);
          end else begin
            r_state   <= RESP;
            r_ready   <= 1'b1;
            r_err     <= 1'b0;
            r_mem_sel <= '0;
            r_mem_we  <= 1'b0;
            r_mem_be  <= '0;
            if (!r_we) r_rdata <= w_rd_ext;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ready     = r_ready;
  assign bus.err       = r_err;
  assign bus.rdata     = r_rdata;
  assign bus.mem_sel   = r_mem_sel;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_be    = r_mem_be;
  assign bus.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_legv8_bus_ctrl.sv
// tb/tb_legv8_bus_ctrl.sv - directed vector bench for legv8_bus_ctrl
module tb_legv8_bus_ctrl;

  logic clock;
  logic reset;
  int   n_vec;
  int   n_mis;

  legv8_bus_ctrl_if #(.DATA_W(64), .ADDR_W(32), .NUM_REGIONS(2)) bus ();

  legv8_bus_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] rd0;
    logic [63:0] rd1;
    logic        e_err;
    logic [63:0] e_rdata;
    logic [1:0]  e_sel;
    logic [31:0] e_maddr;
    logic [7:0]  e_be;
    logic [63:0] e_wdata;
    int          e_lat;
  } vec_t;

  vec_t vecs [14];
  vec_t v_after_reset;

  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    int          k;
    bit          got;
    int          we_cnt;
    int          we_at;
    bit          held_bad;
    bit          sel_bad;
    logic [1:0]  sel1;
    logic [31:0] ma1;
    logic [7:0]  be1;
    logic [63:0] wd1;
    k = 0; got = 0; we_cnt = 0; we_at = 0; held_bad = 0; sel_bad = 0;
    sel1 = '0; ma1 = '0; be1 = '0; wd1 = '0;
    @(negedge clock);
    bus.we        = v.we;
    bus.size      = v.size;
    bus.sext      = v.sext;
    bus.addr      = v.addr;
    bus.wdata     = v.wdata;
    bus.mem_rdata = {v.rd1, v.rd0};
    bus.req       = 1'b1;
    @(posedge clock);
    #1 bus.req = 1'b0;
    while (!got && k < 20) begin
      @(negedge clock);
      k++;
      if (v.e_err && bus.mem_sel != 2'b00) sel_bad = 1;
      if (bus.ready) begin
        got = 1;
      end else begin
        if (k == 1) begin
          sel1 = bus.mem_sel; ma1 = bus.mem_addr; be1 = bus.mem_be; wd1 = bus.mem_wdata;
        end else if (bus.mem_sel !== sel1 || bus.mem_addr !== ma1 || bus.mem_be !== be1 || bus.mem_wdata !== wd1) begin
          held_bad = 1;
        end
        if (bus.mem_we) begin
          we_cnt++;
          we_at = k;
        end
      end
    end
    chk("latency", idx, 64'(k), 64'(v.e_lat));
    chk("err", idx, 64'(bus.err), 64'(v.e_err));
    chk("rdata", idx, bus.rdata, v.e_rdata);
    if (!v.e_err) begin
      chk("mem_sel", idx, 64'(sel1), 64'(v.e_sel));
      chk("mem_addr", idx, 64'(ma1), 64'(v.e_maddr));
      chk("mem_be", idx, 64'(be1), 64'(v.e_be));
      chk("mem_wdata", idx, wd1, v.e_wdata);
      chk("held", idx, 64'(held_bad), 64'd0);
      chk("we_cycles", idx, 64'(we_cnt), v.we ? 64'd1 : 64'd0);
      if (v.we) chk("we_at", idx, 64'(we_at), 64'(v.e_lat - 1));
    end else begin
      chk("sel_idle", idx, 64'(sel_bad), 64'd0);
      chk("we_cycles", idx, 64'(we_cnt), 64'd0);
    end
    @(negedge clock);
    chk("ready_pulse", idx, 64'(bus.ready), 64'd0);
  endtask

  initial begin
    n_vec = 0;
    n_mis = 0;
    reset = 1'b0;
    bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.sext = 1'b0;
    bus.addr = '0; bus.wdata = '0; bus.mem_rdata = '0;

    //        we    size   sext  addr          wdata                  rd0                    rd1                    err   e_rdata                sel    maddr     be     e_wdata                lat
    vecs[0]  = '{1'b1, 2'd3, 1'b0, 32'h20000010, 64'h1122334455667788, 64'h0,                 64'h0,                 1'b0, 64'h0,                 2'b10, 32'h10,  8'hFF, 64'h1122334455667788, 3};
    vecs[1]  = '{1'b0, 2'd0, 1'b1, 32'h20000013, 64'h0,                64'h0,                 64'h0000000080000000,  1'b0, 64'hFFFFFFFFFFFFFF80,  2'b10, 32'h10,  8'h08, 64'h0,                 3};
    vecs[2]  = '{1'b0, 2'd0, 1'b0, 32'h20000013, 64'h0,                64'h0,                 64'h0000000080000000,  1'b0, 64'h80,                2'b10, 32'h10,  8'h08, 64'h0,                 3};
    vecs[3]  = '{1'b1, 2'd1, 1'b0, 32'h20000006, 64'hBEEF,             64'h0,                 64'h0,                 1'b0, 64'h80,                2'b10, 32'h0,   8'hC0, 64'hBEEF000000000000, 3};
    vecs[4]  = '{1'b0, 2'd2, 1'b0, 32'h20000002, 64'h0,                64'h0,                 64'h0,                 1'b1, 64'h0,                 2'b00, 32'h0,   8'h00, 64'h0,                 1};
    vecs[5]  = '{1'b0, 2'd0, 1'b0, 32'h10000000, 64'h0,                64'h0,                 64'h0,                 1'b1, 64'h0,                 2'b00, 32'h0,   8'h00, 64'h0,                 1};
    vecs[6]  = '{1'b0, 2'd2, 1'b1, 32'h00000004, 64'h0,                64'h8000000112345678,  64'h0,                 1'b0, 64'hFFFFFFFF80000001,  2'b01, 32'h0,   8'hF0, 64'h0,                 2};
    vecs[7]  = '{1'b0, 2'd1, 1'b0, 32'h0000000A, 64'h0,                64'h8000000112345678,  64'h0,                 1'b0, 64'h1234,              2'b01, 32'h8,   8'h0C, 64'h0,                 2};
    vecs[8]  = '{1'b0, 2'd1, 1'b0, 32'h00000001, 64'h0,                64'h0,                 64'h0,                 1'b1, 64'h0,                 2'b00, 32'h0,   8'h00, 64'h0,                 1};
    vecs[9]  = '{1'b0, 2'd0, 1'b0, 32'h00000100, 64'h0,                64'h0,                 64'h0,                 1'b1, 64'h0,                 2'b00, 32'h0,   8'h00, 64'h0,                 1};
    vecs[10] = '{1'b0, 2'd3, 1'b1, 32'h200003F8, 64'h0,                64'h0,                 64'hDEADBEEF00C0FFEE,  1'b0, 64'hDEADBEEF00C0FFEE,  2'b10, 32'h3F8, 8'hFF, 64'h0,                 3};
    vecs[11] = '{1'b1, 2'd0, 1'b0, 32'h200003FF, 64'hA5,               64'h0,                 64'h0,                 1'b0, 64'hDEADBEEF00C0FFEE,  2'b10, 32'h3F8, 8'h80, 64'hA500000000000000, 3};
    vecs[12] = '{1'b0, 2'd0, 1'b0, 32'h20000400, 64'h0,                64'h0,                 64'h0,                 1'b1, 64'h0,                 2'b00, 32'h0,   8'h00, 64'h0,                 1};
    vecs[13] = '{1'b0, 2'd3, 1'b0, 32'h20000004, 64'h0,                64'h0,                 64'h0,                 1'b1, 64'h0,                 2'b00, 32'h0,   8'h00, 64'h0,                 1};
    v_after_reset = '{1'b0, 2'd3, 1'b0, 32'h00000008, 64'h0, 64'h0011223344556677, 64'h0, 1'b0, 64'h0011223344556677, 2'b01, 32'h8, 8'hFF, 64'h0, 2};

    repeat (2) @(negedge clock);
    chk("rst_ready", 0, 64'(bus.ready), 64'd0);
    chk("rst_err", 0, 64'(bus.err), 64'd0);
    chk("rst_sel", 0, 64'(bus.mem_sel), 64'd0);
    chk("rst_we", 0, 64'(bus.mem_we), 64'd0);
    chk("rst_be", 0, 64'(bus.mem_be), 64'd0);
    chk("rst_rdata", 0, bus.rdata, 64'd0);
    chk("rst_maddr", 0, 64'(bus.mem_addr), 64'd0);
    chk("rst_wdata", 0, bus.mem_wdata, 64'd0);
    reset = 1'b1;

    for (int i = 0; i < 14; i++) apply(vecs[i], i);

    // Back-to-back ROM dword reads, second req held through RESP
    @(negedge clock);
    bus.we = 1'b0; bus.size = 2'd3; bus.sext = 1'b0; bus.addr = 32'h0;
    bus.mem_rdata = {64'h0, 64'h0123456789ABCDEF};
    bus.req = 1'b1;
    @(posedge clock);
    #1 bus.addr = 32'h8;
    @(negedge clock);
    chk("b2b_sel_a", 100, 64'(bus.mem_sel), 64'h1);
    chk("b2b_rdy_a0", 100, 64'(bus.ready), 64'd0);
    @(negedge clock);
    chk("b2b_rdy_a", 100, 64'(bus.ready), 64'd1);
    chk("b2b_rdata_a", 100, bus.rdata, 64'h0123456789ABCDEF);
    bus.mem_rdata = {64'h0, 64'hFEDCBA9876543210};
    @(posedge clock);
    #1 bus.req = 1'b0;
    @(negedge clock);
    chk("b2b_sel_b", 101, 64'(bus.mem_sel), 64'h1);
    chk("b2b_maddr_b", 101, 64'(bus.mem_addr), 64'h8);
    chk("b2b_rdy_b0", 101, 64'(bus.ready), 64'd0);
    @(negedge clock);
    chk("b2b_rdy_b", 101, 64'(bus.ready), 64'd1);
    chk("b2b_rdata_b", 101, bus.rdata, 64'hFEDCBA9876543210);
    @(negedge clock);
    chk("b2b_rdy_end", 101, 64'(bus.ready), 64'd0);

    // Reset asserted during the first RAM ACCESS cycle
    @(negedge clock);
    bus.we = 1'b1; bus.size = 2'd3; bus.addr = 32'h20000020; bus.wdata = 64'hCAFEF00DCAFEF00D;
    bus.req = 1'b1;
    @(posedge clock);
    #1 bus.req = 1'b0;
    @(negedge clock);
    chk("mid_sel_before", 200, 64'(bus.mem_sel), 64'h2);
    #1 reset = 1'b0;
    #1;
    chk("mid_sel", 200, 64'(bus.mem_sel), 64'd0);
    chk("mid_we", 200, 64'(bus.mem_we), 64'd0);
    chk("mid_ready", 200, 64'(bus.ready), 64'd0);
    chk("mid_be", 200, 64'(bus.mem_be), 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("post_ready", 200, 64'(bus.ready), 64'd0);
    chk("post_we", 200, 64'(bus.mem_we), 64'd0);
    chk("post_rdata", 200, bus.rdata, 64'd0);
    apply(v_after_reset, 201);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
